// File: rtl/rvfpm_commit_sequencer_pkg.sv
// Shared types and constants for the FPU commit sequencer.
//   X_ID_WIDTH  : width of the CORE-V-XIF instruction ID
//   SEQ_DEPTH   : default number of in-flight sequencer entries
//   SEQ_INSTR_W : instruction word width held in each entry
//   seq_entry_t : one sequencer slot {valid, committed, killed, instr, id}
package pa_rvfpm;

    localparam int X_ID_WIDTH  = 4;
    localparam int SEQ_DEPTH   = 4;
    localparam int SEQ_INSTR_W = 32;

    typedef struct packed {
        logic                   valid;
        logic                   committed;
        logic                   killed;
        logic [SEQ_INSTR_W-1:0] instr;
        logic [X_ID_WIDTH-1:0]  id;
    } seq_entry_t;

endpackage

// File: rtl/rvfpm_commit_sequencer_id_cam.sv
// ID lookup for commit transactions.
// Compares commit_id_i against every live, still-pending entry and returns a
// one-hot match vector. Searching starts at head_i so that, should two
// pending entries share an ID, only the oldest one is marked.
//   entries_i   : sequencer entry array
//   head_i      : index of the oldest entry
//   commit_id_i : ID presented on the commit interface
//   match_o     : one-hot (or zero) match vector indexed like entries_i
module rvfpm_id_cam
    import pa_rvfpm::*;
#(
    parameter int DEPTH      = SEQ_DEPTH,
    parameter int X_ID_WIDTH = pa_rvfpm::X_ID_WIDTH,
    localparam int PW        = $clog2(DEPTH)
) (
    input  seq_entry_t            entries_i [DEPTH],
    input  logic [PW-1:0]         head_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    output logic [DEPTH-1:0]      match_o
);

    // Oldest-first scan of pending entries for a matching ID.
    always_comb begin
        logic [PW-1:0] idx_s;
        logic          found_s;
        match_o = '0;
        found_s = 1'b0;
        idx_s   = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = head_i + PW'(k);
            if (!found_s && entries_i[idx_s].valid && !entries_i[idx_s].committed &&
                !entries_i[idx_s].killed && (entries_i[idx_s].id == commit_id_i)) begin
                match_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rvfpm_commit_sequencer.sv
// In-order commit sequencer between the XIF issue/commit ports and the FPU
// execute path. Accepted instructions wait in a circular buffer until they are
// committed (then dispatched in issue order) or killed (then silently dropped).
//   ck, rst_n                : clock, asynchronous active-low reset
//   acc_valid/instr/id       : accepted issue transaction; acc_ready = free slot
//   commit_valid/id/kill     : XIF commit strobe
//   disp_valid/instr/id      : committed head entry offered to the FPU
//   disp_ready               : FPU takes the head entry this cycle
//   count                    : occupied entries
//   commit_miss              : registered pulse, a commit matched no pending entry
module rvfpm_commit_sequencer
    import pa_rvfpm::*;
#(
    parameter int DEPTH      = SEQ_DEPTH,
    parameter int X_ID_WIDTH = pa_rvfpm::X_ID_WIDTH,
    parameter int INSTR_W    = 32,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  acc_valid,
    input  logic [INSTR_W-1:0]    acc_instr,
    input  logic [X_ID_WIDTH-1:0] acc_id,
    output logic                  acc_ready,
    input  logic                  commit_valid,
    input  logic [X_ID_WIDTH-1:0] commit_id,
    input  logic                  commit_kill,
    output logic                  disp_valid,
    output logic [INSTR_W-1:0]    disp_instr,
    output logic [X_ID_WIDTH-1:0] disp_id,
    input  logic                  disp_ready,
    output logic [CW-1:0]         count,
    output logic                  commit_miss
);

    seq_entry_t       entries_q [DEPTH];
    seq_entry_t       entries_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             commit_miss_q, commit_miss_d;

    seq_entry_t       head_entry_s;
    logic [DEPTH-1:0] match_s;
    logic             push_s;
    logic             drop_s;
    logic             pop_s;
    logic             new_hit_s;

    rvfpm_id_cam #(
        .DEPTH      (DEPTH),
        .X_ID_WIDTH (X_ID_WIDTH)
    ) u_id_cam (
        .entries_i   (entries_q),
        .head_i      (head_q),
        .commit_id_i (commit_id),
        .match_o     (match_s)
    );

    assign head_entry_s = entries_q[head_q];
    assign acc_ready    = (count_q != CW'(DEPTH));
    assign push_s       = acc_valid && acc_ready;
    assign disp_valid   = head_entry_s.valid && head_entry_s.committed;
    assign drop_s       = head_entry_s.valid && head_entry_s.killed;
    assign pop_s        = (disp_valid && disp_ready) || drop_s;
    assign disp_instr   = head_entry_s.instr;
    assign disp_id      = head_entry_s.id;
    assign count        = count_q;
    assign commit_miss  = commit_miss_q;

    // A commit only lands on the entry being written when no older pending entry matched.
    assign new_hit_s = push_s && commit_valid && (commit_id == acc_id) && (match_s == '0);

    // Next-state: commit marking, head retirement, tail write and occupancy.
    always_comb begin
        entries_d     = entries_q;
        head_d        = pop_s  ? head_q + PW'(1) : head_q;
        tail_d        = push_s ? tail_q + PW'(1) : tail_q;
        count_d       = count_q;
        commit_miss_d = commit_valid && (match_s == '0) && !new_hit_s;

        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].committed = entries_q[i].committed | (commit_valid & match_s[i] & ~commit_kill);
            entries_d[i].killed    = entries_q[i].killed    | (commit_valid & match_s[i] &  commit_kill);
        end

        if (pop_s) begin
            entries_d[head_q].valid = 1'b0;
        end else begin
            entries_d[head_q].valid = entries_d[head_q].valid;
        end

        // Push never targets the head slot while it is being popped: that would need a full buffer.
        if (push_s) begin
            entries_d[tail_q].valid     = 1'b1;
            entries_d[tail_q].committed = new_hit_s && !commit_kill;
            entries_d[tail_q].killed    = new_hit_s &&  commit_kill;
            entries_d[tail_q].instr     = acc_instr;
            entries_d[tail_q].id        = acc_id;
        end else begin
            entries_d[tail_q].valid     = entries_d[tail_q].valid;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every entry, committed or not.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            entries_q     <= '{default: '0};
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_miss_q <= 1'b0;
        end else begin
            entries_q     <= entries_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_miss_q <= commit_miss_d;
        end
    end

endmodule

// File: tb/tb_rvfpm_commit_sequencer.sv
module tb_rvfpm_commit_sequencer;
    import pa_rvfpm::*;

    localparam int DEPTH = 4;
    localparam int IW    = 4;
    localparam int CW    = 3;

    logic          ck = 1'b0;
    logic          rst_n;
    logic          acc_valid;
    logic [31:0]   acc_instr;
    logic [IW-1:0] acc_id;
    logic          acc_ready;
    logic          commit_valid;
    logic [IW-1:0] commit_id;
    logic          commit_kill;
    logic          disp_valid;
    logic [31:0]   disp_instr;
    logic [IW-1:0] disp_id;
    logic          disp_ready;
    logic [CW-1:0] count;
    logic          commit_miss;

    int checks = 0;
    int errors = 0;

    rvfpm_commit_sequencer #(.DEPTH(DEPTH), .X_ID_WIDTH(IW), .INSTR_W(32)) dut (
        .ck(ck), .rst_n(rst_n),
        .acc_valid(acc_valid), .acc_instr(acc_instr), .acc_id(acc_id), .acc_ready(acc_ready),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .disp_valid(disp_valid), .disp_instr(disp_instr), .disp_id(disp_id), .disp_ready(disp_ready),
        .count(count), .commit_miss(commit_miss)
    );

    always #5 ck = ~ck;

    // Reference model: an ordered list of in-flight instructions.
    // st: 0 = waiting for commit, 1 = committed, 2 = killed.
    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   instr;
        int            st;
    } m_ent_t;
    m_ent_t m_q[$];
    logic   m_miss = 1'b0;

    typedef struct {
        bit av; logic [IW-1:0] aid; logic [31:0] ain;
        bit cv; logic [IW-1:0] cid; bit kl; bit dr;
        bit e_dv; logic [IW-1:0] e_id; int e_cnt; bit e_rdy; bit e_miss;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit in_flight(input logic [IW-1:0] id);
        foreach (m_q[i]) if (m_q[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock edge under the given inputs.
    task automatic model_step(input bit av, input logic [IW-1:0] aid, input logic [31:0] ain,
                              input bit cv, input logic [IW-1:0] cid, input bit kl, input bit dr);
        bit pop;
        bit found;
        if (av) begin
            chk("protocol_push_full", 32'(m_q.size() >= DEPTH), 32'd0);
            chk("protocol_dup_id", 32'(in_flight(aid)), 32'd0);
        end
        pop = (m_q.size() > 0) && ((m_q[0].st == 1 && dr) || m_q[0].st == 2);
        if (av && m_q.size() < DEPTH) m_q.push_back('{aid, ain, 0});
        found = 1'b0;
        if (cv) begin
            foreach (m_q[i]) begin
                if (!found && m_q[i].st == 0 && m_q[i].id == cid) begin
                    m_q[i].st = kl ? 2 : 1;
                    found = 1'b1;
                end
            end
        end
        m_miss = cv && !found;
        if (pop) void'(m_q.pop_front());
    endtask

    task automatic check_model();
        bit exp_dv;
        exp_dv = (m_q.size() > 0) && (m_q[0].st == 1);
        chk("m_disp_valid", 32'(disp_valid), 32'(exp_dv));
        if (exp_dv) begin
            chk("m_disp_id", 32'(disp_id), 32'(m_q[0].id));
            chk("m_disp_instr", disp_instr, m_q[0].instr);
        end
        chk("m_count", 32'(count), 32'(m_q.size()));
        chk("m_acc_ready", 32'(acc_ready), 32'(m_q.size() < DEPTH));
        chk("m_commit_miss", 32'(commit_miss), 32'(m_miss));
    endtask

    // Called at a falling edge: drive inputs, pass one rising edge, check at next falling edge.
    task automatic step(input bit av, input logic [IW-1:0] aid, input logic [31:0] ain,
                        input bit cv, input logic [IW-1:0] cid, input bit kl, input bit dr);
        acc_valid = av; acc_id = aid; acc_instr = ain;
        commit_valid = cv; commit_id = cid; commit_kill = kl; disp_ready = dr;
        model_step(av, aid, ain, cv, cid, kl, dr);
        @(negedge ck);
        check_model();
    endtask

    function automatic void add(input bit av, input logic [IW-1:0] aid, input bit cv,
                                input logic [IW-1:0] cid, input bit kl, input bit dr,
                                input bit e_dv, input logic [IW-1:0] e_id, input int e_cnt,
                                input bit e_rdy, input bit e_miss);
        vec_t v;
        v.av = av; v.aid = aid; v.ain = (aid == 4'd3) ? 32'h00B5_0553 : (32'h1000_0000 | 32'(aid));
        v.cv = cv; v.cid = cid; v.kl = kl; v.dr = dr;
        v.e_dv = e_dv; v.e_id = e_id; v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_miss = e_miss;
        vt.push_back(v);
    endfunction

    initial begin
        logic [IW-1:0] rid;
        logic [IW-1:0] rcid;
        bit            rav;
        bit            rcv;
        int            sel;

        rst_n = 1'b0; acc_valid = 1'b0; acc_instr = '0; acc_id = '0;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; disp_ready = 1'b0;
        repeat (2) @(posedge ck);
        @(negedge ck);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_acc_ready", 32'(acc_ready), 32'd1);
        chk("rst_commit_miss", 32'(commit_miss), 32'd0);
        rst_n = 1'b1;

        //   av aid    cv cid   kl dr   dv id    cnt rdy miss
        add(1, 4'h3,  1, 4'h3, 0, 1,   1, 4'h3, 1, 1, 0);
        add(0, 4'h0,  0, 4'h0, 0, 1,   0, 4'h0, 0, 1, 0);
        add(1, 4'h1,  0, 4'h0, 0, 0,   0, 4'h0, 1, 1, 0);
        add(1, 4'h2,  0, 4'h0, 0, 0,   0, 4'h0, 2, 1, 0);
        add(1, 4'h3,  0, 4'h0, 0, 0,   0, 4'h0, 3, 1, 0);
        add(1, 4'h4,  0, 4'h0, 0, 0,   0, 4'h0, 4, 0, 0);
        add(0, 4'h0,  1, 4'h1, 0, 0,   1, 4'h1, 4, 0, 0);
        add(0, 4'h0,  0, 4'h0, 0, 1,   0, 4'h0, 3, 1, 0);
        add(0, 4'h0,  1, 4'h2, 1, 0,   0, 4'h0, 3, 1, 0);
        add(0, 4'h0,  1, 4'h3, 1, 0,   0, 4'h0, 2, 1, 0);
        add(0, 4'h0,  1, 4'h4, 1, 0,   0, 4'h0, 1, 1, 0);
        add(0, 4'h0,  0, 4'h0, 0, 0,   0, 4'h0, 0, 1, 0);
        add(1, 4'h5,  0, 4'h0, 0, 1,   0, 4'h0, 1, 1, 0);
        add(1, 4'h6,  1, 4'h6, 0, 1,   0, 4'h0, 2, 1, 0);
        add(0, 4'h0,  0, 4'h0, 0, 1,   0, 4'h0, 2, 1, 0);
        add(0, 4'h0,  1, 4'h5, 0, 1,   1, 4'h5, 2, 1, 0);
        add(0, 4'h0,  0, 4'h0, 0, 1,   1, 4'h6, 1, 1, 0);
        add(0, 4'h0,  0, 4'h0, 0, 1,   0, 4'h0, 0, 1, 0);
        add(1, 4'h7,  0, 4'h0, 0, 0,   0, 4'h0, 1, 1, 0);
        add(1, 4'h8,  0, 4'h0, 0, 0,   0, 4'h0, 2, 1, 0);
        add(1, 4'h9,  0, 4'h0, 0, 0,   0, 4'h0, 3, 1, 0);
        add(0, 4'h0,  1, 4'h7, 1, 0,   0, 4'h0, 3, 1, 0);
        add(0, 4'h0,  1, 4'h8, 1, 0,   0, 4'h0, 2, 1, 0);
        add(0, 4'h0,  1, 4'h9, 0, 0,   1, 4'h9, 1, 1, 0);
        add(0, 4'h0,  0, 4'h0, 0, 1,   0, 4'h0, 0, 1, 0);
        add(0, 4'h0,  1, 4'hA, 0, 0,   0, 4'h0, 0, 1, 1);
        add(0, 4'h0,  0, 4'h0, 0, 0,   0, 4'h0, 0, 1, 0);
        add(1, 4'hB,  1, 4'hB, 0, 0,   1, 4'hB, 1, 1, 0);
        add(0, 4'h0,  1, 4'hB, 0, 0,   1, 4'hB, 1, 1, 1);
        add(0, 4'h0,  0, 4'h0, 0, 1,   0, 4'h0, 0, 1, 0);

        foreach (vt[n]) begin
            step(vt[n].av, vt[n].aid, vt[n].ain, vt[n].cv, vt[n].cid, vt[n].kl, vt[n].dr);
            chk($sformatf("vec%0d_disp_valid", n), 32'(disp_valid), 32'(vt[n].e_dv));
            if (vt[n].e_dv) chk($sformatf("vec%0d_disp_id", n), 32'(disp_id), 32'(vt[n].e_id));
            chk($sformatf("vec%0d_count", n), 32'(count), 32'(vt[n].e_cnt));
            chk($sformatf("vec%0d_acc_ready", n), 32'(acc_ready), 32'(vt[n].e_rdy));
            chk($sformatf("vec%0d_commit_miss", n), 32'(commit_miss), 32'(vt[n].e_miss));
        end

        // Asynchronous reset with a committed head stalled on disp_ready=0.
        step(1, 4'hC, 32'hC0DE_000C, 1, 4'hC, 0, 0);
        step(1, 4'hD, 32'hC0DE_000D, 0, 4'h0, 0, 0);
        step(1, 4'hE, 32'hC0DE_000E, 0, 4'h0, 0, 0);
        chk("pre_rst_disp_valid", 32'(disp_valid), 32'd1);
        disp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_acc_ready", 32'(acc_ready), 32'd1);
        m_q.delete();
        m_miss = 1'b0;
        @(negedge ck);
        chk("rst_hold_disp_valid", 32'(disp_valid), 32'd0);
        rst_n = 1'b1;
        step(0, 4'h0, 32'h0, 0, 4'h0, 0, 1);
        chk("post_rst_count", 32'(count), 32'd0);

        // Back-to-back push+commit with dispatch, wrapping the pointers.
        for (int i = 0; i < 10; i++)
            step(1, IW'(i), 32'hA5A5_0000 + 32'(i), 1, IW'(i), 0, 1);
        step(0, 4'h0, 32'h0, 0, 4'h0, 0, 1);
        chk("wrap_final_count", 32'(count), 32'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rav = ($urandom_range(0, 1) == 1) && (m_q.size() < DEPTH);
            do rid = IW'($urandom_range(0, 15)); while (in_flight(rid));
            sel  = $urandom_range(0, 3);
            rcv  = (sel != 3);
            rcid = IW'($urandom_range(0, 15));
            if (sel == 0 && m_q.size() > 0) rcid = m_q[$urandom_range(0, m_q.size() - 1)].id;
            else if (sel == 1) rcid = rid;
            else rcid = rcid;
            step(rav, rid, $urandom(), rcv, rcid, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfpm_commit_sequencer.md
Name: rvfpm_commit_sequencer

Overview:
- Holds FPU instructions that the predecoder has accepted until the CORE-V-XIF commit interface commits or kills them.
- Releases committed instructions to the FPU model's execute path strictly in issue order.
- Sits between the XIF issue/commit ports and the add_accepted_instruction dispatch into the pipeline.
- Killed instructions are discarded without ever reaching the FPU.

Parameters:
- DEPTH, 4, number of in-flight entries; power of two, at least 2.
- X_ID_WIDTH, pa_rvfpm::X_ID_WIDTH, width of the XIF instruction ID.
- INSTR_W, 32, instruction word width.

Ports:
- ck  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- acc_valid  in  1  an accepted issue transaction is presented (issue_valid && issue_ready && accept).
- acc_instr  in  INSTR_W  instruction word of the accepted transaction.
- acc_id  in  X_ID_WIDTH  XIF ID of the accepted transaction.
- acc_ready  out  1  a free entry exists; feeds fpu_ready gating.
- commit_valid  in  1  XIF commit strobe.
- commit_id  in  X_ID_WIDTH  ID being committed.
- commit_kill  in  1  1 = kill the instruction, 0 = commit it.
- disp_valid  out  1  head entry is committed and may be dispatched.
- disp_instr  out  INSTR_W  instruction word of the head entry.
- disp_id  out  X_ID_WIDTH  ID of the head entry.
- disp_ready  in  1  FPU model takes the head entry this cycle.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- commit_miss  out  1  registered one-cycle pulse: a commit matched no live entry.

Behaviour:
- Storage is a circular buffer: head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Each entry holds valid, committed, killed, instr and id.
- Reset (rst_n low, asynchronous): all entry valid bits, head, tail, count and commit_miss go to 0. As a result disp_valid=0 and acc_ready=1.
- acc_ready = (count != DEPTH), combinational. No bypass from full, so push and pop cannot coincide while full.
- Push: when acc_valid && acc_ready, write the entry at tail with valid=1, committed=0, killed=0, then advance tail.
- acc_valid while full is ignored and the entry is lost. This is a protocol error and the bench asserts it never happens.
- Commit lookup: when commit_valid, compare commit_id against every entry with valid=1, committed=0 and killed=0.
  - On a match, set committed (commit_kill=0) or killed (commit_kill=1).
- Same-cycle commit and push with commit_id == acc_id: the commit applies to the entry being written in that cycle.
- No match, including a match only on an already committed or killed entry: state is unchanged and commit_miss pulses high in the next cycle.
- IDs in flight must be unique. The block does not check this; the bench asserts it.
- Head sequencing, one action per cycle:
  - HOLD: head is invalid, or valid but not yet committed or killed. disp_valid=0.
  - DISPATCH: head is valid and committed. disp_valid=1, and disp_instr/disp_id come from the head entry (combinational from registers). When disp_ready=1, clear valid and advance head.
  - DROP: head is valid and killed. disp_valid=0. Clear valid and advance head unconditionally; this costs one cycle per killed entry.
- Latency: an entry pushed and committed in cycle N gives disp_valid=1 in cycle N+1. A later commit in cycle M gives disp_valid in M+1.
- disp_valid must not drop while waiting for disp_ready.
- count update each cycle: +1 on push, -1 on dispatch or drop, unchanged when both happen.
- Younger committed entries wait behind an uncommitted head. There is no out-of-order dispatch.
- Reset asserted mid-operation discards every entry, committed or not. No dispatch occurs in the reset cycle.

Decomposition:
- pa_rvfpm gains:
  - typedef seq_entry_t {valid, committed, killed, instr, id};
  - localparam SEQ_DEPTH = 4.
- The ID comparison sits in a natural sub-module, rvfpm_id_cam. It is parameterised by DEPTH and X_ID_WIDTH, takes the entry array and commit_id, and returns a one-hot match vector.
- Match-vector rule: only entries with valid=1, committed=0 and killed=0 are eligible (per Behaviour). If duplicates slip through despite the bench assertion, only the oldest such entry relative to head is marked.

Test Plan:
- Reset, then push id=3 instr=0x00B50553 with commit id=3 kill=0 in the same cycle, disp_ready=1 -> disp_valid=1 next cycle with disp_id=3 and disp_instr=0x00B50553; count returns 1->0.
- Push ids 1,2,3,4 with no commit -> count=4, acc_ready=0. Commit id=1 -> disp_valid 1 cycle later; dispatching it gives acc_ready=1.
- Push 5,6; commit 6 first, then commit 5 two cycles later -> no dispatch until cycle after commit 5; dispatch order is 5 then 6.
- Push 7,8,9; kill 7 and 8, commit 9 -> 7 and 8 dropped in consecutive cycles, disp_valid for id 9 in the third cycle; id 7 and id 8 never appear on disp_id.
- Commit id=0xA with empty buffer, then re-commit an already committed id -> commit_miss pulses once for each; count unchanged.
- Fill 3 entries with head committed and disp_ready=0, then pull rst_n low asynchronously mid-cycle -> disp_valid=0 and count=0 immediately; after release acc_ready=1 and no stale dispatch; wrap-around checked by 10 back-to-back push/dispatch pairs.
